// File: rtl/aes_key_schedule_if.sv
// Handshake bundle between the AES-128 key schedule and its key source / round datapath.
// The slave modport is the key schedule itself; the master modport is the surrounding logic.
interface aes_key_schedule_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         last_key;
  logic         busy;

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, round_key, round_idx, last_key, busy
  );

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, round_key, round_idx, last_key, busy
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion streaming round keys 0..10 over a valid/ready handshake, one per cycle.
// Define AES_KEY_ZEROIZE_EN to clear all key material when the schedule returns to idle.
module aes_key_schedule (
  input  logic                clk,
  input  logic                rst,
  aes_key_schedule_if.slave   bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_e       state_q;
  logic         key_ready_q;
  logic         rk_valid_q;
  logic         last_q;
  logic         busy_q;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;

  logic [31:0]  rot_d;
  logic [31:0]  sub_d;
  logic [31:0]  temp_d;
  logic [31:0]  w0_d, w1_d, w2_d, w3_d;
  logic [127:0] next_key_d;
  logic [7:0]   rcon_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box built from its definition: inverse as x^254 in GF(2^8) (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One KeyExpansion step from the currently presented round key.
  assign rot_d      = {key_q[23:0], key_q[31:24]};
  assign sub_d      = {sbox(rot_d[31:24]), sbox(rot_d[23:16]),
                       sbox(rot_d[15:8]),  sbox(rot_d[7:0])};
  assign temp_d     = sub_d ^ {rcon_q, 24'h000000};
  assign w0_d       = key_q[127:96] ^ temp_d;
  assign w1_d       = key_q[95:64]  ^ w0_d;
  assign w2_d       = key_q[63:32]  ^ w1_d;
  assign w3_d       = key_q[31:0]   ^ w2_d;
  assign next_key_d = {w0_d, w1_d, w2_d, w3_d};
  assign rcon_d     = xtime(rcon_q);

  // NOTE: every register here, including the 128-bit key, is cleared by reset because the
  // reset values are architecturally visible on the outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      key_q       <= '0;
      idx_q       <= '0;
      rcon_q      <= 8'h01;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key_valid && key_ready_q) begin
            state_q     <= EMIT;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            last_q      <= 1'b0;
            key_q       <= bus.key_in;
            idx_q       <= '0;
            rcon_q      <= 8'h01;
          end
        end
        EMIT: begin
          if (bus.rk_ready) begin
            if (idx_q == LAST_IDX) begin
              // Key acceptance waits for the idle cycle, so back-to-back keys are one cycle apart.
              state_q     <= IDLE;
              key_ready_q <= 1'b1;
              rk_valid_q  <= 1'b0;
              busy_q      <= 1'b0;
              last_q      <= 1'b0;
              rcon_q      <= 8'h01;
`ifdef AES_KEY_ZEROIZE_EN
              key_q       <= '0;
              idx_q       <= '0;
`endif
            end else begin
              key_q  <= next_key_d;
              idx_q  <= idx_q + 4'd1;
              rcon_q <= rcon_d;
              last_q <= (idx_q == LAST_IDX - 4'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.round_key = key_q;
  assign bus.round_idx = idx_q;
  assign bus.last_key  = last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table, stalls, reset, key hold, random keys.
// Reference expansion uses a literal S-box table and word-level FIPS-197 arithmetic.
module tb_aes_key_schedule;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  aes_key_schedule_if bus ();

  aes_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:255][7:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp_rk1;
    logic [127:0] exp_rk10;
    int           stall_at;
    int           stall_len;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] cap1;
  logic [127:0] cap10;

  // Round key n of the FIPS-197 expansion, computed word by word from scratch.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    int          rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 4*n + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t[31:24] = t[31:24] ^ 8'(rc);
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst key_ready", 128'(bus.key_ready), 128'(1));
    check("rst rk_valid",  128'(bus.rk_valid),  128'(0));
    check("rst round_key", bus.round_key,       128'(0));
    check("rst round_idx", 128'(bus.round_idx), 128'(0));
    check("rst last_key",  128'(bus.last_key),  128'(0));
    check("rst busy",      128'(bus.busy),      128'(0));
  endtask

  task automatic check_emit(input logic [127:0] key, input int idx);
    check("emit rk_valid",  128'(bus.rk_valid),  128'(1));
    check("emit busy",      128'(bus.busy),      128'(1));
    check("emit key_ready", 128'(bus.key_ready), 128'(0));
    check("emit round_idx", 128'(bus.round_idx), 128'(idx));
    check("emit last_key",  128'(bus.last_key),  128'(idx == 10));
    check("emit round_key", bus.round_key,       model_rk(key, idx));
  endtask

  task automatic start(input logic [127:0] key);
    check("accept key_ready", 128'(bus.key_ready), 128'(1));
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    bus.rk_ready  = 1'b1;
    step();
    bus.key_valid = 1'b0;
  endtask

  // Follows one schedule from index 0 to the idle cycle, checking every presented key.
  task automatic drain(input logic [127:0] key, input int stall_at, input int stall_len,
                       input bit rand_rdy, input bit hold_kv, input logic [127:0] next_key);
    int idx;
    int stalls;
    int cyc;
    bit done;
    bit rdy;
    logic [127:0] exp_idle;
    idx = 0; stalls = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      check_emit(key, idx);
      if (idx == 1)  cap1  = bus.round_key;
      if (idx == 10) cap10 = bus.round_key;
      rdy = 1'b1;
      if (idx == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else if (rand_rdy) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      bus.rk_ready = rdy;
      if (hold_kv) begin
        bus.key_valid = 1'b1;
        bus.key_in    = (idx == 10 && rdy) ? next_key : rand128();
      end
      step();
      cyc++;
      if (rdy) begin
        if (idx == 10) done = 1'b1;
        else idx++;
      end
    end
    check("schedule completed in budget", 128'(done), 128'(1));
`ifdef AES_KEY_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = model_rk(key, 10);
`endif
    check("idle rk_valid",  128'(bus.rk_valid),  128'(0));
    check("idle last_key",  128'(bus.last_key),  128'(0));
    check("idle busy",      128'(bus.busy),      128'(0));
    check("idle key_ready", 128'(bus.key_ready), 128'(1));
    check("idle round_key", bus.round_key,       exp_idle);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    total = 0;
    bad   = 0;
    cap1  = '0;
    cap10 = '0;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, 0};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, -1, 0};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4, 3};

    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_ready  = 1'b0;
    step();
    step();
    check_reset_state();
    rst = 1'b0;
    step();

    // Known-answer vectors, with and without a consumer stall.
    for (int v = 0; v < 3; v++) begin
      start(vecs[v].key);
      drain(vecs[v].key, vecs[v].stall_at, vecs[v].stall_len, 1'b0, 1'b0, '0);
      check("kat round 1",  cap1,  vecs[v].exp_rk1);
      check("kat round 10", cap10, vecs[v].exp_rk10);
      step();
    end

    // Reset mid-schedule at index 6, with a key offered during the reset cycle.
    k1 = rand128();
    start(k1);
    for (int i = 0; i < 6; i++) step();
    check("pre-reset round_idx", 128'(bus.round_idx), 128'(6));
    rst = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_in    = rand128();
    step();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    check_reset_state();
    step();
    check("no key taken in reset", 128'(bus.rk_valid), 128'(0));
    k1 = rand128();
    start(k1);
    drain(k1, -1, 0, 1'b0, 1'b0, '0);
    step();

    // key_valid held through a schedule; the queued key is taken on the idle cycle.
    k1 = rand128();
    k2 = rand128();
    start(k1);
    drain(k1, -1, 0, 1'b0, 1'b1, k2);
    step();
    bus.key_valid = 1'b0;
    drain(k2, -1, 0, 1'b0, 1'b0, '0);
    step();

    // Random keys with random consumer back-pressure.
    for (int r = 0; r < 6; r++) begin
      k1 = rand128();
      start(k1);
      drain(k1, -1, 0, 1'b1, 1'b0, '0);
      repeat ($urandom_range(1, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
